// File: rtl/frogger_pkg.sv
// Shared types and default constants for the Frogger collision engine.
package frogger_pkg;

    localparam int FROG_COORD_W    = 6;
    localparam int FROG_LIVES_INIT = 3;

    typedef enum logic [2:0] {
        ALIVE,
        HIT,
        RESPAWN,
        INVULN,
        GAME_OVER
    } frog_state_e;

endpackage

// File: rtl/frogger_hit_detect.sv
// Per-car overlap comparators feeding a registered hit vector (stage 1).
module frogger_hit_detect
    import frogger_pkg::*;
#(
    parameter int N_CARS  = 5,
    parameter int COORD_W = FROG_COORD_W,
    parameter int CAR_LEN = 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_N,
    input  logic [COORD_W-1:0]          i_Frogger_X,
    input  logic [COORD_W-1:0]          i_Frogger_Y,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_X,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_Y,
    input  logic [N_CARS-1:0]           i_Car_Valid,
    output logic [N_CARS-1:0]           o_Hit_Vec
);

    // Span end is formed one bit wider so a car near the right edge never wraps to X=0.
    localparam logic [COORD_W:0] LEN_M1 = (COORD_W+1)'(CAR_LEN - 1);

    logic [N_CARS-1:0] car_hit;
    logic [N_CARS-1:0] hit_vec_d;
    logic [N_CARS-1:0] hit_vec_q;

    for (genvar k = 0; k < N_CARS; k++) begin : g_car
        logic [COORD_W-1:0] car_x;
        logic [COORD_W-1:0] car_y;
        logic [COORD_W:0]   car_end;

        assign car_x      = i_Car_X[k*COORD_W +: COORD_W];
        assign car_y      = i_Car_Y[k*COORD_W +: COORD_W];
        assign car_end    = {1'b0, car_x} + LEN_M1;
        assign car_hit[k] = i_Car_Valid[k]
                          && (i_Frogger_Y == car_y)
                          && (i_Frogger_X >= car_x)
                          && ({1'b0, i_Frogger_X} <= car_end);
    end

    // Next hit vector is simply the current comparator outputs.
    always_comb begin
        hit_vec_d = car_hit;
    end

    // Stage 1 register: hit vector, cleared by reset so no stale hit survives it.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            hit_vec_q <= '0;
        end else begin
            hit_vec_q <= hit_vec_d;
        end
    end

    assign o_Hit_Vec = hit_vec_q;

endmodule

// File: rtl/frogger_collision_engine.sv
// Collision/death engine: priority encoder, life/invulnerability FSM (stage 2).
module frogger_collision_engine
    import frogger_pkg::*;
#(
    parameter int N_CARS       = 5,
    parameter int COORD_W      = FROG_COORD_W,
    parameter int CAR_LEN      = 1,
    parameter int LIVES_INIT   = FROG_LIVES_INIT,
    parameter int INVULN_TICKS = 30,
    localparam int HIDX_W      = (N_CARS > 1) ? $clog2(N_CARS) : 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_N,
    input  logic [COORD_W-1:0]          i_Frogger_X,
    input  logic [COORD_W-1:0]          i_Frogger_Y,
    input  logic [COORD_W-1:0]          i_Frogger_Orig_X,
    input  logic [COORD_W-1:0]          i_Frogger_Orig_Y,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_X,
    input  logic [N_CARS*COORD_W-1:0]   i_Car_Y,
    input  logic [N_CARS-1:0]           i_Car_Valid,
    input  logic                        i_Tick,
    input  logic                        i_Restart,
    output logic                        o_Collided,
    output logic [HIDX_W-1:0]           o_Hit_Index,
    output logic                        o_Respawn,
    output logic [COORD_W-1:0]          o_Frogger_X,
    output logic [COORD_W-1:0]          o_Frogger_Y,
    output logic [2:0]                  o_Lives,
    output logic                        o_Invuln,
    output logic                        o_Game_Over
);

    localparam int CNT_W = (INVULN_TICKS > 0) ? $clog2(INVULN_TICKS + 1) : 1;

    logic [N_CARS-1:0] hit_vec;
    logic              hit_any;
    logic [HIDX_W-1:0] hit_idx;

    frog_state_e        state_d,     state_q;
    logic [2:0]         lives_d,     lives_q;
    logic [CNT_W-1:0]   cnt_d,       cnt_q;
    logic [HIDX_W-1:0]  pend_idx_d,  pend_idx_q;
    logic [HIDX_W-1:0]  hit_index_d, hit_index_q;
    logic               collided_d,  collided_q;
    logic               respawn_d,   respawn_q;
    logic [COORD_W-1:0] frog_x_d,    frog_x_q;
    logic [COORD_W-1:0] frog_y_d,    frog_y_q;
    logic               invuln_d,    invuln_q;
    logic               game_over_d, game_over_q;

    // ---- stage 1: registered hit vector ----
    frogger_hit_detect #(
        .N_CARS  (N_CARS),
        .COORD_W (COORD_W),
        .CAR_LEN (CAR_LEN)
    ) u_hit_detect (
        .i_Clk       (i_Clk),
        .i_Rst_N     (i_Rst_N),
        .i_Frogger_X (i_Frogger_X),
        .i_Frogger_Y (i_Frogger_Y),
        .i_Car_X     (i_Car_X),
        .i_Car_Y     (i_Car_Y),
        .i_Car_Valid (i_Car_Valid),
        .o_Hit_Vec   (hit_vec)
    );

    // ---- stage 2: priority encoder and FSM ----
    // Lowest-index car wins when several overlap the frog at once.
    always_comb begin
        hit_idx = '0;
        for (int k = N_CARS - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_idx = HIDX_W'(k);
            end
        end
        hit_any = |hit_vec;
    end

    // Next-state and registered-output logic; the pending index is latched on
    // entry to HIT because the hit vector has moved on by the time HIT acts.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        pend_idx_d  = pend_idx_q;
        hit_index_d = hit_index_q;
        collided_d  = 1'b0;
        respawn_d   = 1'b0;
        frog_x_d    = frog_x_q;
        frog_y_d    = frog_y_q;
        case (state_q)
            ALIVE: begin
                if (hit_any) begin
                    state_d    = HIT;
                    pend_idx_d = hit_idx;
                end
            end
            HIT: begin
                lives_d     = lives_q - 3'd1;
                collided_d  = 1'b1;
                hit_index_d = pend_idx_q;
                state_d     = (lives_q == 3'd1) ? GAME_OVER : RESPAWN;
            end
            RESPAWN: begin
                respawn_d = 1'b1;
                frog_x_d  = i_Frogger_Orig_X;
                frog_y_d  = i_Frogger_Orig_Y;
                cnt_d     = CNT_W'(INVULN_TICKS);
                state_d   = (INVULN_TICKS == 0) ? ALIVE : INVULN;
            end
            INVULN: begin
                if (i_Tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ALIVE;
                    end
                end
            end
            GAME_OVER: begin
                if (i_Restart) begin
                    lives_d = 3'(LIVES_INIT);
                    state_d = RESPAWN;
                end
            end
            default: state_d = ALIVE;
        endcase
        invuln_d    = (state_q == INVULN);
        game_over_d = (state_d == GAME_OVER);
    end

    // FSM state and all registered outputs; synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_N) begin
            state_q     <= ALIVE;
            lives_q     <= 3'(LIVES_INIT);
            cnt_q       <= '0;
            pend_idx_q  <= '0;
            hit_index_q <= '0;
            collided_q  <= 1'b0;
            respawn_q   <= 1'b0;
            frog_x_q    <= '0;
            frog_y_q    <= '0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            pend_idx_q  <= pend_idx_d;
            hit_index_q <= hit_index_d;
            collided_q  <= collided_d;
            respawn_q   <= respawn_d;
            frog_x_q    <= frog_x_d;
            frog_y_q    <= frog_y_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
        end
    end

    assign o_Collided  = collided_q;
    assign o_Hit_Index = hit_index_q;
    assign o_Respawn   = respawn_q;
    assign o_Frogger_X = frog_x_q;
    assign o_Frogger_Y = frog_y_q;
    assign o_Lives     = lives_q;
    assign o_Invuln    = invuln_q;
    assign o_Game_Over = game_over_q;

endmodule

// File: doc/frogger_collision_engine.md
# frogger_collision_engine

Parametrised collision and death-handling engine for the Frogger game core. It compares the frog's tile position against up to `N_CARS` obstacles, each with a configurable horizontal length. On a hit it decrements a lives counter and issues a one-cycle respawn command carrying the origin coordinates. It then holds an invulnerability window, or enters game-over. It sits between the obstacle/frog position registers and the frog movement controller, which consumes `o_Respawn`.

## Interface
Parameters:
- `N_CARS`, default 5: number of obstacle channels, 1..16.
- `COORD_W`, default 6: coordinate width in bits.
- `CAR_LEN`, default 1: obstacle length in tiles along X, 1..4.
- `LIVES_INIT`, default 3: lives loaded at reset and restart, 1..7.
- `INVULN_TICKS`, default 30: `i_Tick` pulses of post-respawn immunity; 0 disables the window.

Ports:
- `i_Clk` in 1: system clock.
- `i_Rst_N` in 1: reset, synchronous, active-low.
- `i_Frogger_X`, `i_Frogger_Y` in `COORD_W`: current frog tile.
- `i_Frogger_Orig_X`, `i_Frogger_Orig_Y` in `COORD_W`: respawn tile.
- `i_Car_X`, `i_Car_Y` in `N_CARS*COORD_W`: packed obstacle positions; car k occupies bits `[k*COORD_W +: COORD_W]`.
- `i_Car_Valid` in `N_CARS`: per-car enable; a car with its bit clear never collides.
- `i_Tick` in 1: frame tick, one-cycle pulse.
- `i_Restart` in 1: leave game-over.
- `o_Collided` out 1: one-cycle pulse on an accepted hit.
- `o_Hit_Index` out `$clog2(N_CARS)` (min 1): car index of the last accepted hit.
- `o_Respawn` out 1: one-cycle pulse; frog controller loads `o_Frogger_X`/`o_Frogger_Y`.
- `o_Frogger_X`, `o_Frogger_Y` out `COORD_W`: respawn target, valid when `o_Respawn` is high.
- `o_Lives` out 3: remaining lives.
- `o_Invuln` out 1: high while hits are ignored.
- `o_Game_Over` out 1: level, high in GAME_OVER.

## Operation
- Hit test for car k: `i_Car_Valid[k]` AND `Y == Car_Y[k]` AND `Car_X[k] <= X <= Car_X[k] + CAR_LEN - 1`. The sum is computed at `COORD_W+1` bits, so there is no wrap-around: a car at X=62 with `CAR_LEN`=3 covers 62 and 63 only.
- When several cars hit in the same cycle, the lowest index wins for `o_Hit_Index`; only one life is lost.
- States and transitions:
  - ALIVE: a hit moves to HIT.
  - HIT: `o_Lives` decrements and `o_Collided` and `o_Hit_Index` are issued. If the new lives value is 0, go to GAME_OVER; otherwise go to RESPAWN.
  - RESPAWN: `o_Respawn` is high and `o_Frogger_X/Y` take `i_Frogger_Orig_X/Y` as sampled this cycle. Next state is INVULN, or ALIVE when `INVULN_TICKS`=0.
  - INVULN: counter loads `INVULN_TICKS` and decrements on each `i_Tick`. Go to ALIVE on the tick that reaches 0. Hits are ignored here.
  - GAME_OVER: hits are ignored. `i_Restart` reloads `LIVES_INIT` and goes to RESPAWN.
- Hits in HIT or RESPAWN are ignored. There is no queued second hit.
- Reset values: state ALIVE; `o_Lives`=`LIVES_INIT`; `o_Hit_Index`=0; `o_Frogger_X/Y`=0; every other output 0; invuln counter 0; hit-vector register 0.

## Timing
- Stage 1 registers the `N_CARS`-bit hit vector. Stage 2 is the FSM.
- Inputs colliding at edge t give HIT at edge t+1. `o_Collided` and the decremented `o_Lives` are visible after edge t+2. `o_Respawn` is visible after edge t+3.
- `o_Invuln` is high from the cycle after `o_Respawn` until the cycle after the final `i_Tick`.
- `i_Tick` arriving in the same cycle as entry to INVULN is not counted.
- `i_Restart` in any state other than GAME_OVER is ignored.
- Reset asserted mid-sequence aborts at the next edge: no `o_Respawn` or `o_Collided` pulse follows, and the pipelined hit vector is cleared.
- `o_Hit_Index` holds its value until the next accepted hit.

## Structure
- Shared package `frogger_pkg` holds:
  - the state enum (ALIVE, HIT, RESPAWN, INVULN, GAME_OVER);
  - the default constants `FROG_COORD_W`=6 and `FROG_LIVES_INIT`=3.
- Sub-module `frogger_hit_detect`, parameterised by `N_CARS`, `COORD_W` and `CAR_LEN`, generates the per-car comparators and the registered hit vector.
- The top level contains the priority encoder, the FSM, the lives counter and the invuln counter.

## Test plan
- Frog (10,5), car2 at (9,5), `CAR_LEN`=2, valid -> `o_Collided` pulse at t+2, `o_Hit_Index`=2, `o_Lives` 3->2. `o_Respawn` at t+3 with orig (32,0).
- Cars 1 and 3 both overlap the frog in the same cycle -> a single pulse, `o_Hit_Index`=1, exactly one life lost.
- `INVULN_TICKS`=4: keep the frog on a car after respawn -> no hit during the 4 ticks. A hit is accepted 2 cycles after the 4th tick.
- Car at X=63, `CAR_LEN`=3, frog at X=0 on the same Y -> no collision (no wrap). `i_Car_Valid`=0 on an overlapping car -> no collision.
- Three hits from `LIVES_INIT`=3 -> `o_Game_Over`=1, `o_Lives`=0, further overlaps ignored. `i_Restart` -> `o_Lives`=3 and an `o_Respawn` pulse.
- `i_Rst_N` low in the cycle after a hit -> no `o_Collided`, `o_Lives`=3, state ALIVE.
